// File: rtl/cmd_pkg.sv
// cmd_pkg: command word shared by the loader, the command queue and the issuer
package cmd_pkg;
    localparam int CMD_W = 32;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  tag;
        logic [23:0] addr;
    } cmd_t;
endpackage

// File: rtl/cmd_queue_mem.sv
// cmd_queue_mem: command storage with two write ports and one registered read port
module cmd_queue_mem
    import cmd_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wa_en_i,
    input  logic [$clog2(DEPTH)-1:0] wa_addr_i,
    input  cmd_t                     wa_data_i,
    input  logic                     wb_en_i,
    input  logic [$clog2(DEPTH)-1:0] wb_addr_i,
    input  cmd_t                     wb_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output cmd_t                     rd_data_o
);
    cmd_t mem_q [DEPTH];
    cmd_t rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wa_en_i) mem_q[wa_addr_i] <= wa_data_i;
        if (wb_en_i) mem_q[wb_addr_i] <= wb_data_i;
    end

    // A read always returns the entry as it was before this edge's writes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rd_data_q <= '0;
        else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;
endmodule

// File: rtl/cmd_requeue_fifo.sv
// cmd_requeue_fifo: command queue with host push, issuer pop and issuer re-queue to head or tail
module cmd_requeue_fifo
    import cmd_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int PUSH_FRONT = 1,
    parameter int AF_THRESH  = 6
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_host_wr,
    input  cmd_t                   i_host_cmd,
    output logic                   o_host_ready,
    input  logic                   issuer_rd_queue,
    output cmd_t                   queue_cmd,
    output logic                   queue_ack,
    input  logic                   issuer_wr_queue,
    input  cmd_t                   issuer_cmd,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_full,
    output logic                   o_almost_full,
    output logic                   o_err_ovf,
    output logic                   o_err_udf
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam bit FRONT = (PUSH_FRONT != 0);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, iss_addr, host_addr;
    logic [CW-1:0] count_q, count_d;
    logic          ack_q, ack_d, ovf_q, ovf_d, udf_q, udf_d;
    logic          pop_fire, iss_acc, host_acc, host_ready;

    always_comb begin
        pop_fire   = issuer_rd_queue && (count_q != '0);
        iss_acc    = issuer_wr_queue && ((count_q < CW'(DEPTH)) || pop_fire);
        // Issuer write-back claims its slot first; the host only gets what is left
        host_ready = (count_q + CW'(iss_acc)) < (CW'(DEPTH) + CW'(pop_fire));
        host_acc   = i_host_wr && host_ready;
        iss_addr   = FRONT ? (pop_fire ? rd_ptr_q : rd_ptr_q - AW'(1)) : wr_ptr_q;
        host_addr  = (!FRONT && iss_acc) ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = rd_ptr_q + AW'(pop_fire) - (FRONT ? AW'(iss_acc) : AW'(0));
        wr_ptr_d   = host_addr + AW'(host_acc);
        count_d    = count_q - CW'(pop_fire) + CW'(iss_acc) + CW'(host_acc);
        ack_d      = pop_fire;
        ovf_d      = ovf_q || (issuer_wr_queue && !iss_acc);
        udf_d      = udf_q || (issuer_rd_queue && !pop_fire);
        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            ack_d    = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ack_q    <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ack_q    <= ack_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    cmd_queue_mem #(.DEPTH(DEPTH)) u_mem (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .wa_en_i   (iss_acc && !i_flush),
        .wa_addr_i (iss_addr),
        .wa_data_i (issuer_cmd),
        .wb_en_i   (host_acc && !i_flush),
        .wb_addr_i (host_addr),
        .wb_data_i (i_host_cmd),
        .rd_en_i   (pop_fire && !i_flush),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (queue_cmd)
    );

    assign o_host_ready  = host_ready;
    assign queue_ack     = ack_q;
    assign o_count       = count_q;
    assign o_empty       = (count_q == '0);
    assign o_full        = (count_q == CW'(DEPTH));
    assign o_almost_full = (count_q >= CW'(AF_THRESH));
    assign o_err_ovf     = ovf_q;
    assign o_err_udf     = udf_q;
endmodule
